// File: rtl/fpnew_shared_issue.sv
// Shares one FPU between NumReq requesters: round-robin issue with per-requester
// credit limits, ID-tagged response steering, flush and busy/error reporting.
// Optional perf counters: define FPNEW_SHARED_ISSUE_PERF_EN.
module fpnew_shared_issue #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned ReqDataWidth   = 256,
  parameter int unsigned Width          = 64,
  parameter int unsigned TagWidth       = 4,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdWidth       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumReq-1:0]            req_valid_i,
  output logic [NumReq-1:0]            req_ready_o,
  input  logic [NumReq*ReqDataWidth-1:0] req_data_i,
  input  logic [NumReq*TagWidth-1:0]   req_tag_i,
  output logic [NumReq-1:0]            rsp_valid_o,
  input  logic [NumReq-1:0]            rsp_ready_i,
  output logic [Width-1:0]             rsp_result_o,
  output logic [4:0]                   rsp_status_o,
  output logic [TagWidth-1:0]          rsp_tag_o,
  output logic                         fpu_req_valid_o,
  input  logic                         fpu_req_ready_i,
  output logic [ReqDataWidth-1:0]      fpu_req_data_o,
  output logic [IdWidth+TagWidth-1:0]  fpu_req_tag_o,
  input  logic                         fpu_rsp_valid_i,
  output logic                         fpu_rsp_ready_o,
  input  logic [Width-1:0]             fpu_rsp_result_i,
  input  logic [4:0]                   fpu_rsp_status_i,
  input  logic [IdWidth+TagWidth-1:0]  fpu_rsp_tag_i,
  input  logic                         flush_i,
  output logic                         fpu_flush_o,
  output logic                         busy_o,
  output logic                         err_o,
  output logic [31:0]                  perf_issued_o,
  output logic [31:0]                  perf_stall_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t               state, state_nxt;
  logic [IdWidth-1:0]   lock_idx, lock_nxt;
  logic [IdWidth-1:0]   rr_ptr, rr_inc;
  logic                 err_q;
  logic [CntWidth-1:0]  cnt     [NumReq];
  logic [CntWidth-1:0]  cnt_nxt [NumReq];

  logic [NumReq-1:0]    eligible;
  logic                 found;
  logic [IdWidth-1:0]   pick;
  logic [IdWidth-1:0]   grant;
  logic                 grant_valid;
  logic                 issue;

  logic [IdWidth-1:0]   rsp_id;
  logic                 id_in_range;
  logic [CntWidth-1:0]  id_cnt;
  logic                 id_ready;
  logic                 routable;
  logic                 route;
  logic                 retire;
  logic                 err_set;

  // Forward side: eligibility and round-robin pick (two passes emulate wrapping)
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      eligible[i] = req_valid_i[i] && (cnt[i] < CntWidth'(MaxOutstanding));
    end
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && eligible[i] && (i >= rr_ptr)) begin
        found = 1'b1;
        pick  = IdWidth'(i);
      end
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && eligible[i]) begin
        found = 1'b1;
        pick  = IdWidth'(i);
      end
    end
  end

  always_comb begin
    if (state == LOCKED) begin
      grant       = lock_idx;
      grant_valid = 1'b1;
    end else begin
      grant       = pick;
      grant_valid = found;
    end
  end

  assign fpu_req_valid_o = grant_valid && !flush_i;
  assign issue           = fpu_req_valid_o && fpu_req_ready_i;
  assign fpu_req_data_o  = req_data_i[grant*ReqDataWidth +: ReqDataWidth];
  assign fpu_req_tag_o   = {grant, req_tag_i[grant*TagWidth +: TagWidth]};
  assign rr_inc          = (grant == IdWidth'(NumReq - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ready_o[i] = issue && (grant == IdWidth'(i));
    end
  end

  // Return side: the ID lookup is a loop so out-of-range IDs never index the arrays
  assign rsp_id = fpu_rsp_tag_i[IdWidth+TagWidth-1:TagWidth];

  always_comb begin
    id_in_range = 1'b0;
    id_cnt      = '0;
    id_ready    = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (rsp_id == IdWidth'(i)) begin
        id_in_range = 1'b1;
        id_cnt      = cnt[i];
        id_ready    = rsp_ready_i[i];
      end
    end
  end

  assign routable        = id_in_range && (id_cnt != '0);
  assign route           = fpu_rsp_valid_i && routable && !flush_i;
  assign fpu_rsp_ready_o = (flush_i || !routable) ? 1'b1 : id_ready;
  assign retire          = route && id_ready;
  assign err_set         = fpu_rsp_valid_i && !routable && !flush_i;

  always_comb begin
    rsp_valid_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      rsp_valid_o[i] = route && (rsp_id == IdWidth'(i));
    end
  end

  assign rsp_result_o = fpu_rsp_result_i;
  assign rsp_status_o = fpu_rsp_status_i;
  assign rsp_tag_o    = fpu_rsp_tag_i[TagWidth-1:0];
  assign fpu_flush_o  = flush_i;
  assign err_o        = err_q;

  // Credit counters: a same-cycle issue and retire on one requester cancel out
  always_comb begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      cnt_nxt[i] = cnt[i];
      if (flush_i) begin
        cnt_nxt[i] = '0;
      end else if (issue && (grant == IdWidth'(i)) && !(retire && (rsp_id == IdWidth'(i)))) begin
        cnt_nxt[i] = cnt[i] + 1'b1;
      end else if (retire && (rsp_id == IdWidth'(i)) && !(issue && (grant == IdWidth'(i)))) begin
        cnt_nxt[i] = cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    lock_nxt  = lock_idx;
    if (flush_i) begin
      state_nxt = UNLOCKED;
    end else begin
      case (state)
        UNLOCKED: begin
          if (fpu_req_valid_o && !fpu_req_ready_i) begin
            state_nxt = LOCKED;
            lock_nxt  = grant;
          end
        end
        LOCKED: begin
          if (fpu_req_ready_i) state_nxt = UNLOCKED;
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= UNLOCKED;
      lock_idx <= '0;
      rr_ptr   <= '0;
      err_q    <= 1'b0;
      for (int unsigned i = 0; i < NumReq; i++) cnt[i] <= '0;
    end else begin
      state    <= state_nxt;
      lock_idx <= lock_nxt;
      if (issue)   rr_ptr <= rr_inc;
      if (err_set) err_q  <= 1'b1;
      for (int unsigned i = 0; i < NumReq; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  always_comb begin
    busy_o = (state == LOCKED);
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (cnt[i] != '0) busy_o = 1'b1;
    end
  end

`ifdef FPNEW_SHARED_ISSUE_PERF_EN
  logic [31:0] issued_q, stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (issue && (issued_q != '1)) issued_q <= issued_q + 1'b1;
      if (fpu_req_valid_o && !fpu_req_ready_i && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  assign perf_issued_o = issued_q;
  assign perf_stall_o  = stall_q;
`else
  assign perf_issued_o = '0;
  assign perf_stall_o  = '0;
`endif

endmodule

// File: tb/tb_fpnew_shared_issue.sv
// Directed bench for fpnew_shared_issue: arbitration order, credit limit, lock
// stability, response steering, unroutable error, flush and reset.
module tb_fpnew_shared_issue;

  localparam int unsigned NumReq = 4;
  localparam int unsigned RDW    = 256;
  localparam int unsigned W      = 64;
  localparam int unsigned TW     = 4;
  localparam int unsigned IW     = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NumReq-1:0]     req_valid;
  logic [NumReq-1:0]     req_ready;
  logic [NumReq*RDW-1:0] req_data;
  logic [NumReq*TW-1:0]  req_tag;
  logic [NumReq-1:0]     rsp_valid;
  logic [NumReq-1:0]     rsp_ready;
  logic [W-1:0]          rsp_result;
  logic [4:0]            rsp_status;
  logic [TW-1:0]         rsp_tag;
  logic                  fpu_req_valid;
  logic                  fpu_req_ready;
  logic [RDW-1:0]        fpu_req_data;
  logic [IW+TW-1:0]      fpu_req_tag;
  logic                  fpu_rsp_valid;
  logic                  fpu_rsp_ready;
  logic [W-1:0]          fpu_rsp_result;
  logic [4:0]            fpu_rsp_status;
  logic [IW+TW-1:0]      fpu_rsp_tag;
  logic                  flush;
  logic                  fpu_flush;
  logic                  busy;
  logic                  err;
  logic [31:0]           perf_issued;
  logic [31:0]           perf_stall;

  int vectors    = 0;
  int miscompares = 0;

  fpnew_shared_issue #(
    .NumReq(NumReq), .ReqDataWidth(RDW), .Width(W), .TagWidth(TW), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data_i(req_data), .req_tag_i(req_tag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_status_o(rsp_status), .rsp_tag_o(rsp_tag),
    .fpu_req_valid_o(fpu_req_valid), .fpu_req_ready_i(fpu_req_ready),
    .fpu_req_data_o(fpu_req_data), .fpu_req_tag_o(fpu_req_tag),
    .fpu_rsp_valid_i(fpu_rsp_valid), .fpu_rsp_ready_o(fpu_rsp_ready),
    .fpu_rsp_result_i(fpu_rsp_result), .fpu_rsp_status_i(fpu_rsp_status),
    .fpu_rsp_tag_i(fpu_rsp_tag),
    .flush_i(flush), .fpu_flush_o(fpu_flush),
    .busy_o(busy), .err_o(err),
    .perf_issued_o(perf_issued), .perf_stall_o(perf_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Return one response for requester id with all response-ready lines high
  task automatic retire(input int id);
    fpu_rsp_valid = 1'b1;
    fpu_rsp_tag   = {2'(id), 4'h5};
    rsp_ready     = '1;
    #1;
    check("retire_valid", 64'(rsp_valid), 64'(4'b0001 << id));
    check("retire_ready", 64'(fpu_rsp_ready), 64'd1);
    tick;
    fpu_rsp_valid = 1'b0;
    rsp_ready     = '0;
  endtask

  function automatic logic [63:0] payload(input int i);
    return 64'hDA7A_0000_0000_0000 + 64'(i);
  endfunction

  initial begin
    rst            = 1'b1;
    req_valid      = '0;
    rsp_ready      = '0;
    fpu_req_ready  = 1'b0;
    fpu_rsp_valid  = 1'b0;
    fpu_rsp_result = 64'h1234_5678_9ABC_DEF0;
    fpu_rsp_status = 5'b00001;
    fpu_rsp_tag    = '0;
    flush          = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      req_data[i*RDW +: RDW] = {192'h0, payload(i)};
      req_tag[i*TW +: TW]    = 4'(8 + i);
    end
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("reset_fpu_valid", 64'(fpu_req_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_perf", 64'(perf_issued), 64'd0);

    // 1: all requesters valid, FPU always ready -> strict round robin
    req_valid     = 4'b1111;
    fpu_req_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t1_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      check("t1_tag", 64'(fpu_req_tag), 64'({2'(k % 4), 4'(8 + k % 4)}));
      check("t1_data", fpu_req_data[63:0], payload(k % 4));
      tick;
    end
    req_valid = '0;
    #1;
    check("t1_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 8; k++) retire(k % 4);
    #1;
    check("t1_drained", 64'(busy), 64'd0);

    // 2: credit limit of 4 on requester 2
    req_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_issue", 64'(req_ready), 64'b0100);
      tick;
    end
    #1;
    check("t2_limit_ready", 64'(req_ready), 64'd0);
    check("t2_limit_valid", 64'(fpu_req_valid), 64'd0);
    retire(2);
    #1;
    check("t2_fifth_issue", 64'(req_ready), 64'b0100);
    tick;
    req_valid = '0;
    for (int k = 0; k < 4; k++) retire(2);
    #1;
    check("t2_drained", 64'(busy), 64'd0);

    // 3: lock on requester 1 (rr now 3) while requester 0 joins
    fpu_req_ready = 1'b0;
    req_valid     = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t3_lock_data", fpu_req_data[63:0], payload(1));
      check("t3_lock_valid", 64'(fpu_req_valid), 64'd1);
      check("t3_lock_ready", 64'(req_ready), 64'd0);
      tick;
      req_valid = 4'b0011;
    end
    #1;
    check("t3_busy_locked", 64'(busy), 64'd1);
    fpu_req_ready = 1'b1;
    #1;
    check("t3_handshake", 64'(req_ready), 64'b0010);
    tick;
    #1;
    check("t3_next_req0", 64'(req_ready), 64'b0001);
    tick;
    req_valid = '0;
    retire(0);
    retire(1);

    // 4: response to requester 3 stalled for two cycles
    req_valid = 4'b1000;
    #1;
    check("t4_issue3", 64'(req_ready), 64'b1000);
    tick;
    req_valid     = '0;
    fpu_rsp_valid = 1'b1;
    fpu_rsp_tag   = {2'd3, 4'hA};
    rsp_ready     = '0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t4_rsp_valid", 64'(rsp_valid), 64'b1000);
      check("t4_fpu_ready", 64'(fpu_rsp_ready), 64'd0);
      check("t4_rsp_tag", 64'(rsp_tag), 64'hA);
      check("t4_rsp_result", rsp_result, 64'h1234_5678_9ABC_DEF0);
      tick;
    end
    rsp_ready = 4'b1000;
    #1;
    check("t4_retire_ready", 64'(fpu_rsp_ready), 64'd1);
    tick;
    fpu_rsp_valid = 1'b0;
    rsp_ready     = '0;
    #1;
    check("t4_cnt_dec", 64'(busy), 64'd0);

    // 5: unroutable response (requester 1 has no credits out)
    fpu_rsp_valid = 1'b1;
    fpu_rsp_tag   = {2'd1, 4'h3};
    #1;
    check("t5_drop_ready", 64'(fpu_rsp_ready), 64'd1);
    check("t5_drop_valid", 64'(rsp_valid), 64'd0);
    check("t5_err_before", 64'(err), 64'd0);
    tick;
    fpu_rsp_valid = 1'b0;
    #1;
    check("t5_err_set", 64'(err), 64'd1);
    tick;
    #1;
    check("t5_err_sticky", 64'(err), 64'd1);

    // 6: build cnt[3..0] = {1,2,0,3} (rr starts at 0), then flush
    req_valid = 4'b1101;
    #1; check("t6_g0", 64'(req_ready), 64'b0001); tick;
    #1; check("t6_g2", 64'(req_ready), 64'b0100); tick;
    #1; check("t6_g3", 64'(req_ready), 64'b1000); tick;
    req_valid = 4'b0101;
    #1; check("t6_g0b", 64'(req_ready), 64'b0001); tick;
    #1; check("t6_g2b", 64'(req_ready), 64'b0100); tick;
    req_valid = 4'b0001;
    #1; check("t6_g0c", 64'(req_ready), 64'b0001); tick;
    flush         = 1'b1;
    req_valid     = 4'b0010;
    fpu_rsp_valid = 1'b1;
    fpu_rsp_tag   = {2'd0, 4'h1};
    rsp_ready     = '1;
    #1;
    check("t6_flush_out", 64'(fpu_flush), 64'd1);
    check("t6_flush_req_valid", 64'(fpu_req_valid), 64'd0);
    check("t6_flush_req_ready", 64'(req_ready), 64'd0);
    check("t6_flush_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_flush_rsp_ready", 64'(fpu_rsp_ready), 64'd1);
    tick;
    flush         = 1'b0;
    req_valid     = '0;
    fpu_rsp_valid = 1'b0;
    rsp_ready     = '0;
    #1;
    check("t6_busy_after", 64'(busy), 64'd0);
    check("t6_err_kept", 64'(err), 64'd1);
    req_valid = 4'b1111;
    #1;
    check("t6_rr_kept", 64'(req_ready), 64'b0010);
    req_valid = '0;
    rst       = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    check("t6_rst_err", 64'(err), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    req_valid = 4'b1111;
    #1;
    check("t6_rst_rr", 64'(req_ready), 64'b0001);
    req_valid = '0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpnew_shared_issue.md
Name: fpnew_shared_issue

Overview:
Issue controller that shares one FPU instance (fpnew_top) between NumReq independent requesters, such as cores or hardware threads.
- Forward side: round-robin arbitration with per-requester outstanding-credit limits; the winner's ID is prepended to the FPU tag.
- Return side: each FPU result is steered back to its owner by decoding that ID.
- Also owns FPU flush and aggregate busy/error reporting.

Parameters:
NumReq, 4, number of requesters (2..16)
ReqDataWidth, 256, opaque request payload width (operands + op/fmt/rnd fields), passed through unmodified
Width, 64, FPU result width
TagWidth, 4, per-requester user tag width
MaxOutstanding, 4, maximum in-flight ops per requester (1..15)
IdWidth, derived $clog2(NumReq) (min 1), requester-ID field width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
req_valid_i  in  NumReq  per-requester request valid
req_ready_o  out  NumReq  per-requester request accepted
req_data_i  in  NumReq*ReqDataWidth  per-requester payload, requester i at slice i
req_tag_i  in  NumReq*TagWidth  per-requester user tag
rsp_valid_o  out  NumReq  one-hot response valid
rsp_ready_i  in  NumReq  per-requester response ready
rsp_result_o  out  Width  response result, shared by all requesters
rsp_status_o  out  5  response flags {NV,DZ,OF,UF,NX}, shared
rsp_tag_o  out  TagWidth  user tag of response, shared
fpu_req_valid_o  out  1  FPU in_valid
fpu_req_ready_i  in  1  FPU in_ready
fpu_req_data_o  out  ReqDataWidth  granted payload
fpu_req_tag_o  out  IdWidth+TagWidth  {id, user tag}
fpu_rsp_valid_i  in  1  FPU out_valid
fpu_rsp_ready_o  out  1  FPU out_ready
fpu_rsp_result_i  in  Width  FPU result
fpu_rsp_status_i  in  5  FPU status
fpu_rsp_tag_i  in  IdWidth+TagWidth  FPU returned tag
flush_i  in  1  flush request
fpu_flush_o  out  1  FPU flush
busy_o  out  1  any op in flight or request locked
err_o  out  1  sticky: unroutable response seen

Behaviour:
- One clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - All counters = 0, lock = UNLOCKED, rr pointer = 0, err_o = 0.
  - Outputs then follow combinationally from the reset state: no valids asserted, busy_o = 0.
- Eligibility: requester i is eligible when req_valid_i[i] && cnt[i] < MaxOutstanding.
- Arbiter FSM (2 states):
  - UNLOCKED: grant goes to the first eligible requester at or after the rr pointer (wrapping).
    - fpu_req_valid_o = 1 combinationally; zero-cycle pass-through.
    - If fpu_req_ready_i = 0: latch the grant index and go to LOCKED.
  - LOCKED: the grant is held fixed.
    - Payload and valid stay stable regardless of newly arriving higher-priority requests.
    - Leave LOCKED on handshake.
- Handshake: req_ready_o[g] = granted && fpu_req_ready_i.
  - On handshake: rr pointer = g+1 mod NumReq; cnt[g]++; state = UNLOCKED.
- fpu_req_valid_o never depends combinationally on fpu_req_ready_i.
- A requester dropping valid while locked is a protocol violation; the controller keeps issuing from the latched index.
- Response routing: id = fpu_rsp_tag_i[IdWidth+TagWidth-1:TagWidth].
  - Normal case: rsp_valid_o[id] = fpu_rsp_valid_i and fpu_rsp_ready_o = rsp_ready_i[id].
  - Shared rsp_* data fields mirror the FPU output each cycle.
  - On response handshake: cnt[id]--.
- Simultaneous issue and retire on the same requester: cnt unchanged. Counters never wrap.
- Unroutable response (id >= NumReq, or cnt[id] == 0):
  - Dropped: fpu_rsp_ready_o = 1, no rsp_valid_o.
  - err_o set; it clears only on reset.
- Flush:
  - fpu_flush_o = flush_i, combinational.
  - In a flush_i cycle: all counters cleared, state = UNLOCKED, no issue handshake counted (fpu_req_valid_o forced 0).
  - Responses are dropped (fpu_rsp_ready_o = 1, rsp_valid_o = 0).
  - rr pointer and err_o are kept.
- busy_o = (state == LOCKED) || any cnt != 0.
- Reset asserted mid-operation: all state is cleared at the next edge. The FPU must be reset in the same cycle; this is the integrator's responsibility.

Optional Feature:
FPNEW_SHARED_ISSUE_PERF_EN
- Defined: adds outputs perf_issued_o[31:0] and perf_stall_o[31:0], both saturating at 0xFFFF_FFFF and cleared by reset only.
  - perf_issued_o counts issue handshakes.
  - perf_stall_o counts cycles with fpu_req_valid_o && !fpu_req_ready_i.
- Undefined: both ports present and tied to 0; no counter flops.

Test Plan:
1. req_valid_i = 4'b1111, fpu_req_ready_i held 1 for 8 cycles, rsp_ready_i = 0 -> grants in order 0,1,2,3,0,1,2,3; each cnt = 2; fpu_req_tag_o[5:4] equals the granted ID.
2. Requester 2 alone issues 5 ops with no responses, MaxOutstanding = 4 -> 4 handshakes; 5th cycle req_ready_o[2] = 0 and fpu_req_valid_o = 0. Return one response tagged id 2 -> 5th op issues the next cycle.
3. Grant to requester 1 with fpu_req_ready_i = 0 for 3 cycles while requester 0 raises valid -> fpu_req_data_o stays requester 1's payload for all 3 cycles; handshake on cycle 4; requester 0 is served next.
4. FPU response tag {2'd3, 4'hA} with rsp_ready_i[3] = 0 for 2 cycles -> rsp_valid_o = 4'b1000 and fpu_rsp_ready_o = 0 throughout; retire on cycle 3; cnt[3] decrements; rsp_tag_o = 4'hA.
5. Response with id 1 while cnt[1] == 0 -> fpu_rsp_ready_o = 1, rsp_valid_o = 0, err_o = 1 from the next cycle and persisting.
6. With cnt = {1,2,0,3}, assert flush_i for one cycle alongside a pending request and response -> fpu_flush_o = 1, no handshakes counted, all cnt = 0, busy_o = 0 the next cycle; rst_i then clears err_o and the rr pointer.
